lsu_wb: RTL

Load/store and writeback stage of the RV32I core. Accepts one memory instruction at a time from execute, runs a single word-aligned access on the data bus, and aligns and extends load data. Load results go straight into the register-file write port (`rf_we`/`rf_wa`/`rf_wdata`). Blocking, one outstanding access.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu_wb.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store-writeback stage: funct3 encodings,
// FSM state type and the funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } lsu_state_t;

  // Stores only have SB/SH/SW; loads add the unsigned byte/halfword forms.
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    if (store) return (f3 > F3_W);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads (combinational).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be    = '0;
    wdata = '0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << addr;
        wdata = {4{sdata[7:0]}};
      end
      F3_H: begin
        be    = 4'b0011 << {addr[1], 1'b0};
        wdata = {2{sdata[15:0]}};
      end
      F3_W: begin
        be    = '1;
        wdata = sdata;
      end
      default: begin
        be    = '0;
        wdata = '0;
      end
    endcase
  end

  always_comb begin
    byte_sel = '0;
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ldata = '0;
    case (funct3)
      F3_B:    ldata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ldata = {24'd0, byte_sel};
      F3_H:    ldata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ldata = {16'd0, half_sel};
      F3_W:    ldata = rdata;
      default: ldata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// RV32I load/store + writeback stage: one blocking word-aligned bus access.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_sdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [31:0]       rf_wdata,
  output logic              lsu_err
);

  lsu_state_t        state_q, state_d;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       ldata_q;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_ldata;
  logic              misalign;
  logic              reject;

  lsu_align u_align (
    .funct3 (f3_q),
    .addr   (addr_q[1:0]),
    .sdata  (sdata_q),
    .rdata  (mem_rdata),
    .be     (al_be),
    .wdata  (al_wdata),
    .ldata  (al_ldata)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject = f3_illegal(req_store, req_funct3) || misalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      rd_q    <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        sdata_q <= req_sdata;
        rd_q    <= req_rd;
      end
      if (state_q == BUS && mem_ack && !store_q) ldata_q <= al_ldata;
    end
  end

  // Outputs decode from state only; req_ready is also gated so it reads 0 during reset.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wdata  = '0;
    lsu_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) state_d = reject ? ERR : BUS;
      end
      BUS: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_be    = store_q ? al_be : 4'b1111;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = store_q ? al_wdata : '0;
        if (mem_ack) state_d = store_q ? IDLE : WB;
      end
      WB: begin
        rf_we    = (rd_q != 5'd0);
        rf_wa    = rd_q;
        rf_wdata = ldata_q;
        state_d  = IDLE;
      end
      ERR: begin
        lsu_err = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
